// File: rtl/g18_pkg.sv
// Shared types and constants for the G18 BPI flash Wishbone bridge.
package g18_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_HI = 3'd1,
        RD_LO = 3'd2,
        ACK   = 3'd3,
        ERR   = 3'd4
    } g18_state_t;

    localparam int G18_ADR_W = 23;

    // Half-word bases of the two ROM images held in the flash.
    localparam logic [G18_ADR_W-1:0] G18_BOOT_BASE = 23'h000000;
    localparam logic [G18_ADR_W-1:0] G18_DIAG_BASE = 23'h400000;

endpackage

// File: rtl/g18_wb_bridge.sv
// Read-only Wishbone slave building 32-bit words from two 16-bit G18 flash reads.
// Optional one-word read cache enabled by defining G18_CACHE_EN.
//
// state | meaning
// IDLE  | waiting for a Wishbone request
// RD_HI | even half-word on the flash bus, fills wb_dat_o[31:16]
// RD_LO | odd half-word on the flash bus, fills wb_dat_o[15:0]
// ACK   | one-cycle read acknowledge
// ERR   | one-cycle error acknowledge for writes
module g18_wb_bridge
    import g18_pkg::*;
#(
    parameter int ADR_W      = G18_ADR_W,
    parameter int RD_LATENCY = 2
) (
    input  logic             sys_clk_i,
    input  logic             sys_rst_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_we_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    output logic             wb_err_o,
    output logic [ADR_W-1:0] g18_adr_o,
    input  logic [15:0]      g18_dat_i,
    output logic             g18_wen_o
);

    localparam logic [3:0] CNT_LAST = 4'(RD_LATENCY - 1);

    g18_state_t       state_q, state_d;
    logic [3:0]       cnt_q;
    logic [ADR_W-2:0] base_q;
    logic [ADR_W-1:0] adr_q;
    logic [31:0]      dat_q;
    logic [ADR_W-2:0] req_word;
    logic             req;
    logic             last_cnt;
    logic             hit;
    logic             unused_bits;

    assign req_word    = wb_adr_i[ADR_W:2];
    assign req         = wb_cyc_i & wb_stb_i;
    assign last_cnt    = (cnt_q == CNT_LAST);
    assign unused_bits = ^{wb_dat_i, wb_sel_i, wb_adr_i[31:ADR_W+1], wb_adr_i[1:0]};

`ifdef G18_CACHE_EN
    logic             c_valid_q;
    logic [ADR_W-2:0] c_tag_q;
    logic [31:0]      c_dat_q;

    assign hit = c_valid_q && (c_tag_q == req_word);

    // Fill on the edge that completes the low half, so an aborted read never fills.
    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            c_valid_q <= 1'b0;
            c_tag_q   <= '0;
            c_dat_q   <= '0;
        end else if (state_q == RD_LO && wb_cyc_i && last_cnt) begin
            c_valid_q <= 1'b1;
            c_tag_q   <= base_q;
            c_dat_q   <= {dat_q[31:16], g18_dat_i};
        end
    end
`else
    assign hit = 1'b0;
`endif

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (wb_we_i)  state_d = ERR;
                    else if (hit) state_d = ACK;
                    else          state_d = RD_HI;
                end
            end
            RD_HI: begin
                if (!wb_cyc_i)     state_d = IDLE;
                else if (last_cnt) state_d = RD_LO;
            end
            RD_LO: begin
                if (!wb_cyc_i)     state_d = IDLE;
                else if (last_cnt) state_d = ACK;
            end
            ACK:     state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        wb_ack_o  = 1'b0;
        wb_err_o  = 1'b0;
        g18_wen_o = 1'b0;
        unique case (state_q)
            RD_HI:   g18_wen_o = 1'b1;
            RD_LO:   g18_wen_o = 1'b1;
            ACK:     wb_ack_o  = 1'b1;
            ERR:     wb_err_o  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            cnt_q  <= '0;
            base_q <= '0;
            adr_q  <= '0;
            dat_q  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_q <= '0;
                    if (req && !wb_we_i) begin
`ifdef G18_CACHE_EN
                        if (hit) dat_q <= c_dat_q;
                        else
`endif
                        begin
                            base_q <= req_word;
                            adr_q  <= {req_word, 1'b0};
                        end
                    end
                end
                RD_HI: begin
                    if (!wb_cyc_i) begin
                        cnt_q <= '0;
                    end else if (last_cnt) begin
                        cnt_q        <= '0;
                        dat_q[31:16] <= g18_dat_i;
                        adr_q        <= {base_q, 1'b1};
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RD_LO: begin
                    if (!wb_cyc_i) begin
                        cnt_q <= '0;
                    end else if (last_cnt) begin
                        cnt_q       <= '0;
                        dat_q[15:0] <= g18_dat_i;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                default: cnt_q <= '0;
            endcase
        end
    end

    assign wb_dat_o  = dat_q;
    assign g18_adr_o = adr_q;

endmodule

// File: tb/tb_g18_wb_bridge.sv
// Self-checking bench for g18_wb_bridge: flash model, per-cycle expectation queue, random traffic.
module tb_g18_wb_bridge;
    import g18_pkg::*;

    localparam int L = 2;

    logic        sys_clk_i = 1'b0;
    logic        sys_rst_i;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o;
    logic [22:0] g18_adr_o;
    logic [15:0] g18_dat_i;
    logic        g18_wen_o;

    g18_wb_bridge #(.ADR_W(23), .RD_LATENCY(L)) dut (
        .sys_clk_i(sys_clk_i), .sys_rst_i(sys_rst_i),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .g18_adr_o(g18_adr_o), .g18_dat_i(g18_dat_i), .g18_wen_o(g18_wen_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Flash contents: fixed words for the directed cases, a hash elsewhere.
    function automatic logic [15:0] flash_word(input logic [22:0] a);
        logic [31:0] t;
        case (a)
            23'h000000: return 16'h1234;
            23'h000001: return 16'h5678;
            23'h400000: return 16'hDEAD;
            23'h400001: return 16'hBEEF;
            default: begin
                t = {9'd0, a} * 32'd40503 + 32'h5A5A;
                return t[15:0] ^ t[31:16];
            end
        endcase
    endfunction

    // Device registers its data one cycle after the address.
    always @(posedge sys_clk_i) g18_dat_i <= flash_word(g18_adr_o);

    typedef struct packed {
        logic        ack;
        logic        err;
        logic        wen;
        logic [22:0] adr;
        logic [31:0] dat;
        logic        dat_chk;
    } exp_t;

    exp_t exp_q[$];

    logic [22:0] m_adr;
    bit          m_valid;
    logic [21:0] m_tag;
    logic [31:0] m_dat;

    task automatic push(input logic a, input logic e, input logic w, input logic [22:0] ad,
                        input logic [31:0] d, input logic dc);
        exp_t x;
        x.ack = a; x.err = e; x.wen = w; x.adr = ad; x.dat = d; x.dat_chk = dc;
        exp_q.push_back(x);
    endtask

    always @(negedge sys_clk_i) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("ack", 32'(wb_ack_o), 32'(e.ack));
            chk("err", 32'(wb_err_o), 32'(e.err));
            chk("wen", 32'(g18_wen_o), 32'(e.wen));
            chk("g18_adr", 32'(g18_adr_o), 32'(e.adr));
            if (e.dat_chk) chk("dat", wb_dat_o, e.dat);
        end
    end

    int          cyc_n = 0;
    int          ack_cyc, err_cyc, wen_cnt, ack_cnt, err_cnt;
    logic [31:0] last_dat;

    always @(posedge sys_clk_i) cyc_n <= cyc_n + 1;

    always @(negedge sys_clk_i) begin
        if (wb_ack_o) begin ack_cyc = cyc_n; ack_cnt++; last_dat = wb_dat_o; end
        if (wb_err_o) begin err_cyc = cyc_n; err_cnt++; end
        if (g18_wen_o) wen_cnt++;
    end

    task automatic run_read(input logic [31:0] badr, input int abort_at, input bit drop_stb);
        logic [21:0] w;
        logic [22:0] hi, lo;
        logic [31:0] word;
        int n;
        bit is_hit;
        w    = badr[23:2];
        hi   = {w, 1'b0};
        lo   = {w, 1'b1};
        word = {flash_word(hi), flash_word(lo)};
        is_hit = 1'b0;
`ifdef G18_CACHE_EN
        is_hit = m_valid && (m_tag == w);
`endif
        push(0, 0, 0, m_adr, '0, 0);
        if (is_hit) begin
            push(1, 0, 0, m_adr, m_dat, 1);
            n = 2;
        end else begin
            n = 1;
            for (int k = 1; k <= 2 * L; k++) begin
                if (abort_at != 0 && k > abort_at) break;
                m_adr = (k <= L) ? hi : lo;
                push(0, 0, 1, m_adr, '0, 0);
                n++;
            end
            if (abort_at == 0) begin
                push(1, 0, 0, m_adr, word, 1);
                m_valid = 1'b1; m_tag = w; m_dat = word;
            end else begin
                push(0, 0, 0, m_adr, '0, 0);
            end
            n++;
        end
        wb_adr_i = badr; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        for (int c = 1; c <= n; c++) begin
            @(posedge sys_clk_i); #1;
            if (c == 1 && drop_stb) wb_stb_i = 1'b0;
            if ((abort_at != 0 && c == abort_at) || c == n) begin
                wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
            end
        end
    endtask

    task automatic run_write(input logic [31:0] badr);
        push(0, 0, 0, m_adr, '0, 0);
        push(0, 1, 0, m_adr, '0, 0);
        wb_adr_i = badr; wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        wb_dat_i = $urandom;
        for (int c = 1; c <= 2; c++) begin
            @(posedge sys_clk_i); #1;
            if (c == 2) begin wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; end
        end
    endtask

    task automatic idle(input int n);
        for (int c = 0; c < n; c++) begin
            push(0, 0, 0, m_adr, '0, 0);
            @(posedge sys_clk_i); #1;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        int start, acks0, n_txn;
        logic [31:0] r;
        logic [21:0] w;
        sys_rst_i = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = 4'hF;
        wb_we_i = 1'b0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        m_adr = '0; m_valid = 1'b0; m_tag = '0; m_dat = '0;
        ack_cnt = 0; err_cnt = 0; wen_cnt = 0; ack_cyc = -1; err_cyc = -1;
        #2;
        chk("rst_ack", 32'(wb_ack_o), 32'd0);
        chk("rst_err", 32'(wb_err_o), 32'd0);
        chk("rst_wen", 32'(g18_wen_o), 32'd0);
        chk("rst_adr", 32'(g18_adr_o), 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        repeat (2) @(posedge sys_clk_i);
        #1 sys_rst_i = 1'b0;
        idle(2);

        // Boot ROM word 0
        start = cyc_n; wen_cnt = 0;
        run_read(32'h0000_0000, 0, 0);
        chk("boot_lat", 32'(ack_cyc - start), 32'd5);
        chk("boot_dat", last_dat, 32'h12345678);
        chk("boot_wen_cycles", 32'(wen_cnt), 32'd4);

        // Diag ROM, half-word 0x400000
        wen_cnt = 0;
        run_read(32'h0080_0000, 0, 0);
        chk("diag_dat", last_dat, 32'hDEADBEEF);
        chk("diag_wen_cycles", 32'(wen_cnt), 32'd4);

        run_read(32'h0100_0000, 0, 0);
        chk("upper_bits_ignored", last_dat, 32'h12345678);

        // Write is rejected
        start = cyc_n; wen_cnt = 0; acks0 = ack_cnt;
        run_write(32'h0000_0000);
        chk("err_lat", 32'(err_cyc - start), 32'd1);
        chk("err_no_wen", 32'(wen_cnt), 32'd0);
        chk("err_no_ack", 32'(ack_cnt), 32'(acks0));

        // Abort in cycle 3, then a clean read of the same word
        acks0 = ack_cnt;
        run_read(32'h0000_0004, 3, 0);
        chk("abort_no_ack", 32'(ack_cnt), 32'(acks0));
        run_read(32'h0000_0004, 0, 0);
        chk("after_abort_dat", last_dat, {flash_word(23'd2), flash_word(23'd3)});

`ifdef G18_CACHE_EN
        start = cyc_n;
        run_read(32'h0000_0000, 0, 0);
        chk("cache_miss_lat", 32'(ack_cyc - start), 32'd5);
        start = cyc_n; wen_cnt = 0;
        run_read(32'h0000_0000, 0, 0);
        chk("cache_hit_lat", 32'(ack_cyc - start), 32'd1);
        chk("cache_hit_no_wen", 32'(wen_cnt), 32'd0);
        chk("cache_hit_dat", last_dat, 32'h12345678);
        start = cyc_n;
        run_read(32'h0000_0004, 0, 0);
        chk("cache_evict_lat", 32'(ack_cyc - start), 32'd5);
        start = cyc_n;
        run_read(32'h0000_0000, 0, 0);
        chk("cache_refetch_lat", 32'(ack_cyc - start), 32'd5);
`endif

        // Reset in cycle 2 of a read
        push(0, 0, 0, m_adr, '0, 0);
        push(0, 0, 1, 23'd6, '0, 0);
        wb_adr_i = 32'h0000_000C; wb_we_i = 1'b0; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
        @(posedge sys_clk_i); #1;
        @(posedge sys_clk_i); #1;
        sys_rst_i = 1'b1;
        #1;
        chk("midrst_ack", 32'(wb_ack_o), 32'd0);
        chk("midrst_err", 32'(wb_err_o), 32'd0);
        chk("midrst_wen", 32'(g18_wen_o), 32'd0);
        chk("midrst_adr", 32'(g18_adr_o), 32'd0);
        chk("midrst_dat", wb_dat_o, 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(posedge sys_clk_i); #1;
        sys_rst_i = 1'b0;
        m_adr = '0; m_valid = 1'b0;
        acks0 = ack_cnt;
        idle(4);
        chk("midrst_no_ack", 32'(ack_cnt), 32'(acks0));

        // Random traffic
        n_txn = 300;
        for (int t = 0; t < n_txn; t++) begin
            r = $urandom;
            case ($urandom_range(0, 6))
                0, 1, 2, 3: w = 22'($urandom_range(0, 3));
                4:          w = 22'h200000;
                5:          w = 22'h3FFFFF;
                default:    w = 22'($urandom);
            endcase
            case ($urandom_range(0, 9))
                0, 1:    run_write({r[31:24], w, r[1:0]});
                2, 3:    run_read({r[31:24], w, r[1:0]}, $urandom_range(1, 2 * L), r[5]);
                default: run_read({r[31:24], w, r[1:0]}, 0, r[6]);
            endcase
            if (r[7]) idle($urandom_range(1, 2));
        end

        idle(3);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
